// File: rtl/parking_pkg.sv
// Shared types and widths for the parking-lot control unit.
package parking_pkg;

    localparam int HOUR_W = 4;
    localparam int SPOT_W = 2;

    typedef enum logic {
        DAY,
        END
    } main_state_t;

    typedef enum logic [1:0] {
        NONE,
        ACTIVE,
        DONE
    } rush_state_t;

endpackage

// File: rtl/parking_control_if.sv
// Event/status bundle between the parking control unit and its driver/datapath.
interface parking_control_if;
    import parking_pkg::*;

    // Event inputs are single-cycle pulses with no back-pressure: a pulse is
    // consumed on the rising edge that samples it, and every output below is
    // registered and valid from the edge after the pulse.
    logic              car_enter;
    logic              car_exit;
    logic              hour_adv;
    logic              slow_tick;

    logic [SPOT_W-1:0] spots_left;
    logic [HOUR_W-1:0] time_in;
    logic [HOUR_W-1:0] incr_in;
    logic [HOUR_W-1:0] addr_in;
    logic              startRush;
    logic              stopRush;
    logic              rushEnded;
    logic              endGameHexOut;

    // Debug visibility of both FSMs.
    main_state_t       main_state;
    rush_state_t       rush_state;

    modport master (
        output car_enter, car_exit, hour_adv, slow_tick,
        input  spots_left, time_in, incr_in, addr_in,
        input  startRush, stopRush, rushEnded, endGameHexOut,
        input  main_state, rush_state
    );

    modport slave (
        input  car_enter, car_exit, hour_adv, slow_tick,
        output spots_left, time_in, incr_in, addr_in,
        output startRush, stopRush, rushEnded, endGameHexOut,
        output main_state, rush_state
    );

endinterface

// File: rtl/rush_tracker.sv
// Rush-hour window FSM: NONE -> ACTIVE on lot full, ACTIVE -> DONE on lot empty.
module rush_tracker
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SPOT_W-1:0] spots_next,
    input  logic              en,
    output logic              startRush,
    output logic              stopRush,
    output logic              rushEnded,
    output rush_state_t       state
);

    localparam logic [SPOT_W-1:0] SPOTS_MAX = SPOT_W'(NUM_SPOTS);

    rush_state_t state_q, state_d;
    logic        start_d, stop_d;
    logic        start_q, stop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NONE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    // Watches the post-update occupancy so the pulse lands with the hour it belongs to.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (en) begin
            case (state_q)
                NONE: if (spots_next == '0) begin
                    state_d = ACTIVE;
                    start_d = 1'b1;
                end
                ACTIVE: if (spots_next == SPOTS_MAX) begin
                    state_d = DONE;
                    stop_d  = 1'b1;
                end
                DONE:    state_d = DONE;
                default: state_d = NONE;
            endcase
        end
    end

    assign startRush = start_q;
    assign stopRush  = stop_q;
    assign rushEnded = (state_q == DONE);
    assign state     = state_q;

endmodule

// File: rtl/parking_control.sv
// Parking-lot control: occupancy, hour of day, per-hour arrivals and end-of-day readback.
// Define PARKING_RUSH_TRACK_EN to build in the rush-hour tracker.
module parking_control
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS = 3,
    parameter int NUM_HOURS = 8
) (
    input  logic               clk,
    input  logic               reset,
    parking_control_if.slave   bus
);

    localparam logic [SPOT_W-1:0] SPOTS_MAX  = SPOT_W'(NUM_SPOTS);
    localparam logic [HOUR_W-1:0] LAST_HOUR  = HOUR_W'(NUM_HOURS - 1);
    localparam logic [HOUR_W-1:0] HOURS_DONE = HOUR_W'(NUM_HOURS);

    main_state_t       state_q, state_d;
    logic [SPOT_W-1:0] spots_q, spots_d, spots_after_exit;
    logic [HOUR_W-1:0] time_q, time_d;
    logic [HOUR_W-1:0] incr_q, incr_d;
    logic [HOUR_W-1:0] addr_q, addr_d;
    logic              exit_ok, enter_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DAY;
            spots_q <= SPOTS_MAX;
            time_q  <= '0;
            incr_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            spots_q <= spots_d;
            time_q  <= time_d;
            incr_q  <= incr_d;
            addr_q  <= addr_d;
        end
    end

    // Exit is applied first, so a full lot can swap one car out and one in.
    always_comb begin
        exit_ok          = bus.car_exit && (spots_q < SPOTS_MAX);
        spots_after_exit = spots_q + {{(SPOT_W-1){1'b0}}, exit_ok};
        enter_ok         = bus.car_enter && (spots_after_exit != '0);
    end

    always_comb begin
        state_d = state_q;
        spots_d = spots_q;
        time_d  = time_q;
        incr_d  = incr_q;
        addr_d  = addr_q;
        case (state_q)
            DAY: begin
                spots_d = spots_after_exit - {{(SPOT_W-1){1'b0}}, enter_ok};
                if (enter_ok && (incr_q != '1)) begin
                    incr_d = incr_q + HOUR_W'(1);
                end
                if (bus.hour_adv) begin
                    if (time_q == LAST_HOUR) begin
                        state_d = END;
                        time_d  = HOURS_DONE;
                        incr_d  = '0;
                        addr_d  = '0;
                    end else begin
                        time_d  = time_q + HOUR_W'(1);
                        incr_d  = {{(HOUR_W-1){1'b0}}, enter_ok};
                    end
                end
            end
            END: begin
                if (bus.slow_tick) begin
                    addr_d = (addr_q == LAST_HOUR) ? '0 : addr_q + HOUR_W'(1);
                end
            end
            default: state_d = DAY;
        endcase
    end

    assign bus.spots_left    = spots_q;
    assign bus.time_in       = time_q;
    assign bus.incr_in       = incr_q;
    assign bus.addr_in       = addr_q;
    assign bus.endGameHexOut = (state_q == END);
    assign bus.main_state    = state_q;

`ifdef PARKING_RUSH_TRACK_EN
    logic        start_rush, stop_rush, rush_ended;
    rush_state_t rush_state;

    rush_tracker #(
        .NUM_SPOTS (NUM_SPOTS)
    ) u_rush_tracker (
        .clk        (clk),
        .reset      (reset),
        .spots_next (spots_d),
        .en         (state_q == DAY),
        .startRush  (start_rush),
        .stopRush   (stop_rush),
        .rushEnded  (rush_ended),
        .state      (rush_state)
    );

    assign bus.startRush  = start_rush;
    assign bus.stopRush   = stop_rush;
    assign bus.rushEnded  = rush_ended;
    assign bus.rush_state = rush_state;
`else
    assign bus.startRush  = 1'b0;
    assign bus.stopRush   = 1'b0;
    assign bus.rushEnded  = 1'b0;
    assign bus.rush_state = NONE;
`endif

endmodule

// File: tb/tb_parking_control.sv
// Directed bench for parking_control (NUM_SPOTS=3, NUM_HOURS=8).
module tb_parking_control;
    import parking_pkg::*;

`ifdef PARKING_RUSH_TRACK_EN
    localparam logic R = 1'b1;
`else
    localparam logic R = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    parking_control_if bus ();

    parking_control #(
        .NUM_SPOTS (3),
        .NUM_HOURS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Applies one cycle of event pulses and returns #1 after the sampling edge.
    task automatic step(input logic en, input logic ex, input logic ha, input logic st);
        @(negedge clk);
        bus.car_enter = en;
        bus.car_exit  = ex;
        bus.hour_adv  = ha;
        bus.slow_tick = st;
        @(posedge clk);
        #1;
        bus.car_enter = 1'b0;
        bus.car_exit  = 1'b0;
        bus.hour_adv  = 1'b0;
        bus.slow_tick = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int sp, input int tm, input int inc,
                           input int ad, input logic sr, input logic pr, input logic re,
                           input logic eg);
        chk({tag, ".spots"},   32'(bus.spots_left),    32'(sp));
        chk({tag, ".time"},    32'(bus.time_in),       32'(tm));
        chk({tag, ".incr"},    32'(bus.incr_in),       32'(inc));
        chk({tag, ".addr"},    32'(bus.addr_in),       32'(ad));
        chk({tag, ".start"},   32'(bus.startRush),     32'(sr));
        chk({tag, ".stop"},    32'(bus.stopRush),      32'(pr));
        chk({tag, ".ended"},   32'(bus.rushEnded),     32'(re));
        chk({tag, ".endgame"}, 32'(bus.endGameHexOut), 32'(eg));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.car_enter = 1'b0;
        bus.car_exit  = 1'b0;
        bus.hour_adv  = 1'b0;
        bus.slow_tick = 1'b0;
        #12;
        chk_all("reset", 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill the lot in hour 0.
        step(1, 0, 0, 0); chk_all("fill1", 2, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); chk_all("fill2", 1, 0, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); chk_all("fill3", 0, 0, 3, 0, R, 0, 0, 0);
        step(0, 0, 0, 0); chk_all("idle1", 0, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); chk_all("enter_full", 0, 0, 3, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0); chk_all("swap_full", 0, 0, 4, 0, 0, 0, 0, 0);

        // Empty the lot in hour 2.
        step(0, 0, 1, 0); chk_all("hour1", 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0); chk_all("hour2", 0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0); chk_all("exit1", 1, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0); chk_all("exit2", 2, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0); chk_all("exit3", 3, 2, 0, 0, 0, R, R, 0);
        step(0, 0, 0, 0); chk_all("idle2", 3, 2, 0, 0, 0, 0, R, 0);
        step(0, 1, 0, 0); chk_all("exit_empty", 3, 2, 0, 0, 0, 0, R, 0);

        // Refill: no second rush window.
        step(1, 0, 0, 0); chk_all("refill1", 2, 2, 1, 0, 0, 0, R, 0);
        step(1, 0, 0, 0); chk_all("refill2", 1, 2, 2, 0, 0, 0, R, 0);
        step(1, 0, 0, 0); chk_all("refill3", 0, 2, 3, 0, 0, 0, R, 0);
        step(0, 1, 0, 0); chk_all("free_one", 1, 2, 3, 0, 0, 0, R, 0);
        step(1, 0, 1, 0); chk_all("hour_enter", 0, 3, 1, 0, 0, 0, R, 0);

        step(0, 0, 1, 0); chk_all("hour4", 0, 4, 0, 0, 0, 0, R, 0);
        step(0, 0, 1, 0); chk_all("hour5", 0, 5, 0, 0, 0, 0, R, 0);
        step(0, 0, 1, 0); chk_all("hour6", 0, 6, 0, 0, 0, 0, R, 0);
        step(0, 0, 1, 0); chk_all("hour7", 0, 7, 0, 0, 0, 0, R, 0);
        // Final hour advance with a coincident slow_tick: tick must be ignored.
        step(0, 0, 1, 1); chk_all("day_end", 0, 8, 0, 0, 0, 0, R, 1);
        step(1, 1, 1, 0); chk_all("end_ignore", 0, 8, 0, 0, 0, 0, R, 1);

        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("tick%0d.addr", i), 32'(bus.addr_in), 32'(i % 8));
            chk($sformatf("tick%0d.endgame", i), 32'(bus.endGameHexOut), 32'd1);
        end
        step(1, 0, 1, 0); chk_all("end_ignore2", 0, 8, 0, 1, 0, 0, R, 1);

        // Asynchronous reset in the middle of a low clock phase.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        step(1, 1, 0, 0); chk_all("swap_empty", 2, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); chk_all("rerun1", 1, 0, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0); chk_all("rerun2", 0, 0, 3, 0, R, 0, 0, 0);
        step(0, 0, 0, 0); chk_all("rerun_idle", 0, 0, 3, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
